// File: rtl/logic_op_pkg.sv
// Shared op codes, FSM encoding and widths for the logic-op scheduler.
package logic_op_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'b000;
    localparam logic [OP_W-1:0] OP_OR     = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR    = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND   = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR    = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'b101;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; the single home of the op-code decode.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // NOTE: y gets a default before the case so no path can infer a latch.
    always_comb begin
        y = a;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_PASS_A: y = a;
            OP_NOT_A:  y = ~a;
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Command FIFO plus IDLE/EXEC/DONE sequencer around the logic unit; results
// are held on a valid/ready port with zero/parity flags and a handshake count.
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_parity,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    cmd_t             cmd_in, fifo_head;

    state_e           state_q, state_d;
    cmd_t             issue_q, issue_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_parity_q, res_parity_d;
    logic [15:0]      op_count_q, op_count_d;
    logic [WIDTH-1:0] lu_y;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign cmd_in     = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_in;
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op (issue_q.op),
        .a  (issue_q.a),
        .b  (issue_q.b),
        .y  (lu_y)
    );

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        res_parity_d = res_parity_q;
        op_count_d   = op_count_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    issue_d = fifo_head;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d   = lu_y;
                res_zero_d   = (lu_y == '0);
                res_parity_d = ^lu_y;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    // Chain straight into the next command to sustain one result per two cycles.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        issue_d = fifo_head;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            issue_q      <= '0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b0;
            res_parity_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_q      <= issue_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_parity_q <= res_parity_d;
            op_count_q   <= op_count_d;
        end
    end

    assign res_valid  = (state_q == ST_DONE);
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_parity = res_parity_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler: single ops, all op codes, flags,
// back-pressure, streaming order, counter wrap and mid-operation reset.
module tb_logic_op_scheduler;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_parity;
    logic             busy;
    logic [15:0]      op_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic_op_scheduler #(.WIDTH(WIDTH), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_parity (res_parity),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return ~(a ^ b);
            3'b110:  return a;
            default: return ~a;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_res(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, " timeout"}, {31'd0, res_valid}, 32'd1);
    endtask

    // Starts and ends at a negedge; res_ready must already be 1.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_res(tag);
        check({tag, " data"},   {24'd0, res_data},     {24'd0, exp});
        check({tag, " zero"},   {31'd0, res_zero},     {31'd0, (exp == '0)});
        check({tag, " parity"}, {31'd0, res_parity},   {31'd0, ^exp});
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [2:0]       v_op [3];
    logic [WIDTH-1:0] v_a  [3];
    logic [WIDTH-1:0] v_b  [3];
    logic [WIDTH-1:0] v_y  [3];

    initial begin
        logic [WIDTH-1:0] ops_exp [8];
        int got_n;
        int sent;
        int rcv;
        bit push_now;

        // Reset state
        #2;
        check("rst res_valid", {31'd0, res_valid}, 32'd0);
        check("rst busy",      {31'd0, busy},      32'd0);
        check("rst op_count",  {16'd0, op_count},  32'd0);
        check("rst res_data",  {24'd0, res_data},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Single op with explicit latency
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 8'b00110001;
        cmd_b     = 8'b00110100;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t1 valid N+0", {31'd0, res_valid}, 32'd0);
        check("t1 busy",      {31'd0, busy},      32'd1);
        @(negedge clk);
        check("t1 valid N+1", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("t1 valid N+2", {31'd0, res_valid},  32'd1);
        check("t1 data",      {24'd0, res_data},   {24'd0, 8'b00110000});
        check("t1 zero",      {31'd0, res_zero},   32'd0);
        check("t1 parity",    {31'd0, res_parity}, 32'd0);
        @(negedge clk);
        check("t1 valid after hs", {31'd0, res_valid}, 32'd0);
        check("t1 op_count",       {16'd0, op_count},  32'd1);
        check("t1 idle busy",      {31'd0, busy},      32'd0);

        // All op codes on one operand pair
        ops_exp = '{8'b00000010, 8'b10011111, 8'b10011101, 8'b11111101,
                    8'b01100000, 8'b01100010, 8'b10000111, 8'b01111000};
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("t2 op%0d", i), 3'(i), 8'b10000111, 8'b00011010, ops_exp[i]);
        end

        // Zero flag
        run_op("t3 xor-zero", 3'b010, 8'b01100001, 8'b01100001, 8'h00);
        check("t3 op_count", {16'd0, op_count}, 32'd10);

        // Back-pressure
        do_reset();
        res_ready = 1'b0;
        v_op = '{3'b000, 3'b010, 3'b100};
        v_a  = '{8'hF0, 8'hAA, 8'h00};
        v_b  = '{8'h3C, 8'h0F, 8'h00};
        v_y  = '{8'h30, 8'hA5, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = v_op[i];
            cmd_a     = v_a[i];
            cmd_b     = v_b[i];
            check($sformatf("t4 ready push%0d", i), {31'd0, cmd_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        cmd_op = 3'b001;
        cmd_a  = 8'h55;
        cmd_b  = 8'h55;
        check("t4 ready full",  {31'd0, cmd_ready}, 32'd0);
        check("t4 held valid",  {31'd0, res_valid}, 32'd1);
        check("t4 held data",   {24'd0, res_data},  32'h30);
        @(negedge clk);
        @(negedge clk);
        check("t4 still full",  {31'd0, cmd_ready}, 32'd0);
        check("t4 stable data", {24'd0, res_data},  32'h30);
        check("t4 no count",    {16'd0, op_count},  32'd0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        got_n = 0;
        for (int c = 0; c < 20 && got_n < 3; c++) begin
            if (res_valid) begin
                check($sformatf("t4 result%0d", got_n), {24'd0, res_data}, {24'd0, v_y[got_n]});
                got_n++;
            end
            @(negedge clk);
        end
        check("t4 results", got_n, 32'd3);
        check("t4 op_count", {16'd0, op_count}, 32'd3);

        // Streaming with simultaneous push and pop
        do_reset();
        res_ready = 1'b1;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 1000 && rcv < 100; c++) begin
            if (res_valid) begin
                check($sformatf("t5 stream%0d", rcv), {24'd0, res_data},
                      {24'd0, ref_op(3'(rcv % 8), 8'(rcv * 37 + 5), 8'(rcv * 91 + 3))});
                rcv++;
            end
            push_now = 1'b0;
            if (sent < 100) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'(sent % 8);
                cmd_a     = 8'(sent * 37 + 5);
                cmd_b     = 8'(sent * 91 + 3);
                push_now  = cmd_ready;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            if (push_now) sent++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("t5 received", rcv, 32'd100);
        check("t5 op_count", {16'd0, op_count}, 32'd100);

        // Counter wrap
        force dut.op_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.op_count_q;
        check("t5 preload", {16'd0, op_count}, 32'h0000FFFE);
        run_op("t5 wrap a", 3'b001, 8'h0F, 8'hF0, 8'hFF);
        check("t5 count ffff", {16'd0, op_count}, 32'h0000FFFF);
        run_op("t5 wrap b", 3'b011, 8'hFF, 8'h0F, 8'hF0);
        check("t5 count wrap", {16'd0, op_count}, 32'd0);

        // Reset mid-operation with two commands queued
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = v_op[i];
            cmd_a     = v_a[i];
            cmd_b     = v_b[i];
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("t6 pre valid", {31'd0, res_valid}, 32'd1);
        check("t6 pre full",  {31'd0, cmd_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst valid",    {31'd0, res_valid}, 32'd0);
        check("t6 rst busy",     {31'd0, busy},      32'd0);
        check("t6 rst op_count", {16'd0, op_count},  32'd0);
        check("t6 rst data",     {24'd0, res_data},  32'd0);
        check("t6 rst ready",    {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        run_op("t6 after rst", 3'b000, 8'b00110001, 8'b00110100, 8'b00110000);
        check("t6 op_count", {16'd0, op_count}, 32'd1);
        check("t6 drained",  {31'd0, busy},     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
